seq_product_divider: RTL



---
 rtl/seq_product_divider.sv | 128 ++++++++++++
 1 files changed

// File: rtl/seq_product_divider.sv
// Radix-2 restoring divider: 16-bit product / 8-bit operand, one quotient bit per clock behind start/done.
// Build option: define APPROX_LSB_TRUNC_EN to zero dividend[3:0] at capture (truncated-nibble multiplier model).
module seq_product_divider (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] dividend,
    input  logic [7:0]  divisor,
    output logic        busy,
    output logic        done,
    output logic [15:0] quotient,
    output logic [7:0]  remainder,
    output logic        div_by_zero,
    output logic        q_ovf
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [7:0]  rem_q, rem_d;
    logic [15:0] dvd_q, dvd_d;
    logic [7:0]  dvs_q, dvs_d;
    logic [15:0] quo_q, quo_d;
    logic [7:0]  rmd_q, rmd_d;
    logic        dbz_q, dbz_d;
    logic        ovf_q, ovf_d;

    logic [15:0] cap_dvd;
    logic [8:0]  shifted;
    logic        ge;
    logic [7:0]  iter_rem;
    logic [15:0] iter_dvd;

`ifdef APPROX_LSB_TRUNC_EN
    assign cap_dvd = {dividend[15:4], 4'h0};
`else
    assign cap_dvd = dividend;
`endif

    // The 9-bit partial remainder only exists after the shift; the stored one always fits 8 bits.
    assign shifted  = {rem_q, dvd_q[15]};
    assign ge       = shifted >= {1'b0, dvs_q};
    assign iter_rem = ge ? 8'(shifted - {1'b0, dvs_q}) : shifted[7:0];
    assign iter_dvd = {dvd_q[14:0], ge};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        quo_d   = quo_q;
        rmd_d   = rmd_q;
        dbz_d   = dbz_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    dvd_d = cap_dvd;
                    dvs_d = divisor;
                    rem_d = 8'h00;
                    cnt_d = 4'd0;
                    if (divisor == 8'h00) begin
                        state_d = DONE;
                        quo_d   = 16'hFFFF;
                        rmd_d   = 8'h00;
                        dbz_d   = 1'b1;
                        ovf_d   = 1'b1;
                    end else begin
                        state_d = RUN;
                    end
                end else if (state_q == DONE) begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                rem_d = iter_rem;
                dvd_d = iter_dvd;
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd15) begin
                    state_d = DONE;
                    quo_d   = iter_dvd;
                    rmd_d   = iter_rem;
                    dbz_d   = 1'b0;
                    ovf_d   = |iter_dvd[15:8];
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            rem_q   <= 8'h00;
            dvd_q   <= 16'h0000;
            dvs_q   <= 8'h00;
            quo_q   <= 16'h0000;
            rmd_q   <= 8'h00;
            dbz_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            quo_q   <= quo_d;
            rmd_q   <= rmd_d;
            dbz_q   <= dbz_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy        = (state_q == RUN);
    assign done        = (state_q == DONE);
    assign quotient    = quo_q;
    assign remainder   = rmd_q;
    assign div_by_zero = dbz_q;
    assign q_ovf       = ovf_q;

endmodule
